// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// A requester is granted in IDLE, the registered ALU drive is held for one
// EXEC cycle, and the captured result is presented in RESP until consumed.
// Illegal opcodes never disturb the ALU drive; they return err=1, result=0.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without
// it req0 has fixed priority and no pointer register exists.
// dbg_state exposes the FSM: 0 = IDLE, 1 = EXEC, 2 = RESP.
// Handshakes: a request transfers on a posedge where reqN_valid && reqN_ready;
// a response transfers on a posedge where rsp_valid && rsp_ready; rsp_* are
// held stable while rsp_valid is high and rsp_ready is low.
module alu_arbiter #(
   parameter int DW = 32  // only 32 is supported
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   input  logic [3:0]    req0_op,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [3:0]    req1_op,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   output logic          req1_ready,
   output logic [3:0]    alu_op,
   output logic [DW-1:0] alu_din1,
   output logic [DW-1:0] alu_din2,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_zf,
   output logic          rsp_valid,
   output logic          rsp_id,
   output logic [DW-1:0] rsp_result,
   output logic          rsp_zf,
   output logic          rsp_err,
   input  logic          rsp_ready,
   output logic [1:0]    dbg_state
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] RESP = 2'b10;

   logic [1:0]    state_q, state_d;
   logic          grant0, grant1, grant_any;
   logic [3:0]    sel_op;
   logic [DW-1:0] sel_a, sel_b;
   logic          sel_legal;

   logic          id_q;
   logic          ill_q;
   logic [3:0]    alu_op_q;
   logic [DW-1:0] alu_din1_q, alu_din2_q;
   logic          rsp_id_q;
   logic [DW-1:0] rsp_result_q;
   logic          rsp_zf_q;
   logic          rsp_err_q;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
         default:                                              op_legal = 1'b0;
      endcase
   endfunction

`ifdef ALU_ARB_RR_EN
   // 1 means requester 1 wins the next contention.
   logic rr_q;

   // Round-robin choice; a lone requester always wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && state_q == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~rr_q;
            grant1 = rr_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   // Pointer moves only on a grant, towards the requester not just served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= 1'b0;
      end else if (grant_any) begin
         rr_q <= ~grant1;
      end
   end
`else
   // Fixed priority: req0 wins any contention.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && state_q == IDLE) begin
         grant0 = req0_valid;
         grant1 = req1_valid & ~req0_valid;
      end
   end
`endif

   assign grant_any  = grant0 | grant1;
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Mux the winning request's fields.
   always_comb begin
      sel_op    = req0_op;
      sel_a     = req0_a;
      sel_b     = req0_b;
      if (grant1) begin
         sel_op = req1_op;
         sel_a  = req1_a;
         sel_b  = req1_b;
      end
      sel_legal = op_legal(sel_op);
   end

   // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP always, RESP -> IDLE on accept.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_any) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the granted request and capture the ALU output at the end of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q         <= 1'b0;
         ill_q        <= 1'b0;
         alu_op_q     <= 4'b0000;
         alu_din1_q   <= '0;
         alu_din2_q   <= '0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zf_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         if (grant_any) begin
            id_q  <= grant1;
            ill_q <= ~sel_legal;
            // The ALU drive keeps its previous value for an illegal opcode.
            if (sel_legal) begin
               alu_op_q   <= sel_op;
               alu_din1_q <= sel_a;
               alu_din2_q <= sel_b;
            end
         end
         if (state_q == EXEC) begin
            rsp_id_q <= id_q;
            if (ill_q) begin
               rsp_result_q <= '0;
               rsp_zf_q     <= 1'b0;
               rsp_err_q    <= 1'b1;
            end else begin
               rsp_result_q <= alu_result;
               rsp_zf_q     <= alu_zf;
               rsp_err_q    <= 1'b0;
            end
         end
      end
   end

   assign alu_op     = alu_op_q;
   assign alu_din1   = alu_din1_q;
   assign alu_din2   = alu_din2_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zf     = rsp_zf_q;
   assign rsp_err    = rsp_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: models the shared ALU, drives requests, and
// checks every accepted response against an expected queue built from the
// opcode rules.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [3:0]  req0_op = '0, req1_op = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_ready, req1_ready;
   logic [3:0]  alu_op;
   logic [31:0] alu_din1, alu_din2;
   logic [31:0] alu_result;
   logic        alu_zf;
   logic        rsp_valid, rsp_id, rsp_zf, rsp_err;
   logic [31:0] rsp_result;
   logic        rsp_ready = 1'b0;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   bit rand_rdy = 1'b0;

   // expected response {id, err, zf, result}
   logic [34:0] exp_q[$];
   logic [3:0]  last_op = 4'b0000;
   logic [31:0] last_a = '0, last_b = '0;

   alu_arbiter #(.DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ready(req1_ready),
      .alu_op(alu_op), .alu_din1(alu_din1), .alu_din2(alu_din2),
      .alu_result(alu_result), .alu_zf(alu_zf),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_zf(rsp_zf), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish before 400000");
      $fatal(1);
   end

   // shared combinational ALU
   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_din1 & alu_din2;
         4'b0001: alu_result = alu_din1 | alu_din2;
         4'b0010: alu_result = alu_din1 + alu_din2;
         4'b0110: alu_result = alu_din1 - alu_din2;
         4'b0111: alu_result = (alu_din1 < alu_din2) ? 32'd1 : 32'd0;
         4'b1100: alu_result = ~(alu_din1 | alu_din2);
         default: alu_result = 32'hA5A5_A5A5;
      endcase
      alu_zf = (alu_result == 32'd0);
   end

   // reference model: what a response must contain for a given request
   function automatic logic [34:0] model(input logic id, input logic [3:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        err;
      r = 32'd0;
      err = 1'b0;
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd6:  r = a - b;
         4'd7:  r = (a < b) ? 32'd1 : 32'd0;
         4'd12: r = ~(a | b);
         default: err = 1'b1;
      endcase
      return {id, err, (!err && r == 32'd0), r};
   endfunction

   function automatic bit is_legal(input logic [3:0] op);
      return (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd6 || op == 4'd7 || op == 4'd12);
   endfunction

   // scoreboard: every accepted response must match the head of exp_q
   always begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid && rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got id=%0d result=%h with no response expected", rsp_id, rsp_result);
         end else begin
            logic [34:0] e;
            e = exp_q.pop_front();
            if ({rsp_id, rsp_err, rsp_zf, rsp_result} !== e) begin
               errors++;
               $display("FAIL sb_response: got id=%0d err=%0d zf=%0d result=%h, required id=%0d err=%0d zf=%0d result=%h",
                        rsp_id, rsp_err, rsp_zf, rsp_result, e[34], e[33], e[32], e[31:0]);
            end
         end
      end
   end

   // random consumer back-pressure
   always @(negedge clk) if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));

   // driver: present a request and hold it until granted; returns #1 after the grant edge
   task automatic issue(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bit got;
      got = 1'b0;
      @(negedge clk);
      if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL grant_timeout: requester %0d got ready=0, required a grant within 20 cycles", id);
      end else begin
         exp_q.push_back(model(id, op, a, b));
         if (is_legal(op)) begin last_op = op; last_a = a; last_b = b; end
         @(posedge clk);
      end
      #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   // driver: wait until all expected responses have been consumed
   task automatic drain(input int budget);
      for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #3 rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd3; req0_b = 32'd4;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready: got %b required 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_ready: got %b required 0", req1_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
      checks++; if ({rsp_id, rsp_zf, rsp_err} !== 3'b000) begin errors++; $display("FAIL rst_rsp_flags: got %b required 000", {rsp_id, rsp_zf, rsp_err}); end
      checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL rst_rsp_result: got %h required 0", rsp_result); end
      checks++; if (alu_op !== 4'd0) begin errors++; $display("FAIL rst_alu_op: got %h required 0", alu_op); end
      checks++; if ({alu_din1, alu_din2} !== 64'd0) begin errors++; $display("FAIL rst_alu_din: got %h %h required 0 0", alu_din1, alu_din2); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d required 0 (IDLE)", dbg_state); end
      // first grant on the first posedge after release
      rst_n = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_first_grant: got ready=%b required 1", req0_ready); end
      exp_q.push_back(model(1'b0, 4'd2, 32'd3, 32'd4));
      last_op = 4'd2; last_a = 32'd3; last_b = 32'd4;
      @(posedge clk);
      #1 req0_valid = 1'b0;
      drain(10);
   endtask

   task automatic test_add_latency();
      rsp_ready = 1'b0;
      issue(1'b0, 4'd2, 32'h7FFF_FFFF, 32'd1);
      @(negedge clk);
      checks++; if (dbg_state !== 2'd1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL add_exec: got state=%0d rsp_valid=%b required 1 and 0", dbg_state, rsp_valid); end
      checks++; if ({alu_op, alu_din1, alu_din2} !== {4'd2, 32'h7FFF_FFFF, 32'd1}) begin errors++; $display("FAIL add_alu_drive: got %h %h %h required 2 7fffffff 1", alu_op, alu_din1, alu_din2); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got rsp_valid=%b two cycles after grant, required 1", rsp_valid); end
      checks++; if ({rsp_id, rsp_err, rsp_zf, rsp_result} !== {3'b000, 32'h8000_0000}) begin errors++; $display("FAIL add_result: got id=%0d err=%0d zf=%0d result=%h required 0 0 0 80000000", rsp_id, rsp_err, rsp_zf, rsp_result); end
      rsp_ready = 1'b1;
      drain(5);
      rsp_ready = 1'b0;
   endtask

   task automatic test_sub_hold();
      rsp_ready = 1'b0;
      issue(1'b1, 4'd6, 32'd5, 32'd5);
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd1; req0_b = 32'd2;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_err, rsp_zf, rsp_result} !== {4'b1101, 32'd0}) begin
            errors++;
            $display("FAIL sub_hold_c%0d: got valid=%b id=%0d err=%0d zf=%0d result=%h required 1 1 0 1 0", c, rsp_valid, rsp_id, rsp_err, rsp_zf, rsp_result);
         end
         checks++;
         if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL sub_no_grant_c%0d: got ready=%b required 00", c, {req0_ready, req1_ready}); end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 req0_valid = 1'b0;
      drain(5);
      rsp_ready = 1'b0;
   endtask

   task automatic test_illegal();
      logic [3:0]  pop;
      logic [31:0] pa, pb;
      pop = last_op; pa = last_a; pb = last_b;
      rsp_ready = 1'b0;
      issue(1'b0, 4'b0011, $urandom(), $urandom());
      @(negedge clk);
      checks++; if ({alu_op, alu_din1, alu_din2} !== {pop, pa, pb}) begin errors++; $display("FAIL ill_alu_unchanged: got %h %h %h required %h %h %h", alu_op, alu_din1, alu_din2, pop, pa, pb); end
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_zf, rsp_result} !== {4'b1010, 32'd0}) begin errors++; $display("FAIL ill_rsp: got valid=%b id=%0d err=%0d zf=%0d result=%h required 1 0 1 0 0", rsp_valid, rsp_id, rsp_err, rsp_zf, rsp_result); end
      rsp_ready = 1'b1;
      drain(5);
   endtask

   task automatic test_slt_nor();
      rsp_ready = 1'b1;
      issue(1'b0, 4'd7, 32'hFFFF_FFFF, 32'd1);
      repeat (2) @(negedge clk);
      checks++; if ({rsp_valid, rsp_zf, rsp_result} !== {2'b11, 32'd0}) begin errors++; $display("FAIL slt_unsigned: got valid=%b zf=%0d result=%h required 1 1 0", rsp_valid, rsp_zf, rsp_result); end
      drain(5);
      issue(1'b1, 4'd12, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      checks++; if ({rsp_valid, rsp_zf, rsp_result} !== {2'b10, 32'hFFFF_FFFF}) begin errors++; $display("FAIL nor_zero: got valid=%b zf=%0d result=%h required 1 0 ffffffff", rsp_valid, rsp_zf, rsp_result); end
      drain(5);
   endtask

   task automatic test_contention();
      logic exp_ids[4];
      bit   got;
      logic winner;
`ifdef ALU_ARB_RR_EN
      exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      apply_reset();
      rsp_ready = 1'b1;
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd10; req0_b = 32'd20;
      req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'hF0; req1_b = 32'h0F;
      for (int g = 0; g < 4; g++) begin
         got = 1'b0;
         for (int k = 0; k < 10 && !got; k++) begin
            #1;
            if (req0_ready === 1'b1 || req1_ready === 1'b1) got = 1'b1;
            else @(negedge clk);
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL cont_timeout_g%0d: got no grant, required one within 10 cycles", g);
            break;
         end
         winner = req1_ready;
         checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL cont_onehot_g%0d: got ready=11 required one-hot", g); end
         checks++; if (winner !== exp_ids[g]) begin errors++; $display("FAIL cont_order_g%0d: got id=%0d required %0d", g, winner, exp_ids[g]); end
         exp_q.push_back(winner ? model(1'b1, 4'd1, 32'hF0, 32'h0F) : model(1'b0, 4'd2, 32'd10, 32'd20));
         @(posedge clk);
         if (g != 3) @(negedge clk);
      end
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      last_op = winner ? 4'd1 : 4'd2;
      last_a = winner ? 32'hF0 : 32'd10;
      last_b = winner ? 32'h0F : 32'd20;
      drain(10);
   endtask

   task automatic test_reset_resp();
      rsp_ready = 1'b0;
      issue(1'b0, 4'd0, $urandom(), $urandom());
      repeat (2) @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_pre_valid: got %b required 1", rsp_valid); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rr_async_clear: got valid=%b state=%0d required 0 0", rsp_valid, dbg_state); end
      exp_q.delete();
      last_op = 4'd0; last_a = 32'd0; last_b = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_no_stale_c%0d: got rsp_valid=%b required 0", c, rsp_valid); end
      end
      issue(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2);
      drain(10);
   endtask

   task automatic test_random();
      logic [3:0]  legal_ops[6];
      logic [3:0]  op;
      logic [31:0] a, b;
      legal_ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 6) == 0) begin
            op = 4'($urandom_range(0, 15));
            while (is_legal(op)) op = 4'($urandom_range(0, 15));
         end else begin
            op = legal_ops[$urandom_range(0, 5)];
         end
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
         b = ($urandom_range(0, 3) == 0) ? a : $urandom();
         issue(1'($urandom_range(0, 1)), op, a, b);
         drain(60);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rand_rdy = 1'b0;
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_sub_hold();
      test_illegal();
      test_slt_nor();
      test_contention();
      test_reset_resp();
      test_random();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d outstanding, required 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DW, 32, operand/result width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  in  1  requester n has an operation pending.
REQ-005 req0_op / req1_op  in  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (unsigned), 1100 NOR.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  DW  operands.
REQ-007 req0_ready / req1_ready  out  1  one-cycle grant pulse; the request is accepted when valid && ready.
REQ-008 alu_op  out  4, alu_din1  out  DW, alu_din2  out  DW  registered drive to the shared ALU.
REQ-009 alu_result  in  DW, alu_zf  in  1  combinational ALU outputs.
REQ-010 rsp_valid  out  1, rsp_id  out  1 (requester index), rsp_result  out  DW, rsp_zf  out  1, rsp_err  out  1 (illegal opcode).
REQ-011 rsp_ready  in  1  consumer accepts the response when rsp_valid && rsp_ready.

Function
REQ-012 FSM states: IDLE, EXEC, RESP; no other reachable state.
REQ-013 IDLE: if any req_valid, grant exactly one requester (ready=1 for one cycle), latch its op/a/b/id, and go to EXEC; otherwise stay.
REQ-014 Legal opcode: in EXEC, alu_op/alu_din1/alu_din2 hold the latched values; at the end of EXEC capture alu_result and alu_zf into rsp_result/rsp_zf, set rsp_err=0, and go to RESP.
REQ-015 Illegal opcode: the ALU is not driven (alu_op and operands unchanged); rsp_result=0, rsp_zf=0, rsp_err=1; EXEC is still one cycle.
REQ-016 RESP: rsp_valid=1; rsp_* remain stable until rsp_ready=1; on that handshake go to IDLE.
REQ-017 Latency: grant at cycle N, EXEC at N+1, rsp_valid at N+2; minimum 3 cycles between grants.
REQ-018 req_ready is 0 in EXEC and RESP; requests arriving then wait; req_valid dropped before a grant is not an error.
REQ-019 Simultaneous req0_valid and req1_valid: arbitrate per REQ-026 or REQ-027; the other requester is untouched.
REQ-020 rsp_zf is the ALU's ZF for the captured result (1 iff result==0), including SUB equality checks.
REQ-021 ADD/SUB wrap modulo 2^32; no carry or overflow output.

Reset
REQ-022 While rst_n=0: state=IDLE, both req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zf=0, rsp_err=0, alu_op=0000, alu_din1=0, alu_din2=0, round-robin pointer=0 (next preference req0).
REQ-023 Reset asserted mid-EXEC or mid-RESP discards the operation; no response is ever issued for it.
REQ-024 First grant possible on the first posedge after rst_n deasserts.

Configuration
REQ-025 Macro ALU_ARB_RR_EN selects the arbitration policy.
REQ-026 Defined: round-robin; after a grant to n, the pointer prefers requester 1-n on the next contention; the pointer updates only on grant.
REQ-027 Undefined: fixed priority, req0 always wins contention; no pointer register exists.

Verification
REQ-028 req0 ADD a=0x7FFFFFFF b=1 -> rsp_valid 2 cycles after grant, result 0x80000000, zf=0, id=0, err=0.
REQ-029 req1 SUB a=5 b=5 -> result 0, zf=1, id=1; hold rsp_ready=0 for 4 cycles -> rsp_* stable, no new grant.
REQ-030 Both valid continuously, 4 ops -> RR_EN: ids 0,1,0,1; no RR_EN: ids 0,0,0,0.
REQ-031 req0 op=0011 -> rsp_err=1, result 0, zf=0, alu_op unchanged from prior value.
REQ-032 SLT a=0xFFFFFFFF b=1 -> result 0 (unsigned), zf=1; NOR a=0 b=0 -> 0xFFFFFFFF, zf=0.
REQ-033 rst_n low during RESP -> rsp_valid 0 immediately (async); no response after release; next request serviced normally.
